// File: rtl/lpm_mp_pkg.sv
// lpm_mp_pkg: shared entry field offsets, FSM encodings and the wrapping bitmap search helper.
package lpm_mp_pkg;
  localparam int HDR_W = 65;
  localparam int VALID_OFS = 0;
  localparam int IP_OFS = 1;
  localparam int MASK_OFS = 33;
  typedef logic [2:0] lk_state_t;
  localparam lk_state_t S_IDLE = 3'd0;
  localparam lk_state_t S_SCAN = 3'd1;
  localparam lk_state_t S_DRAIN = 3'd2;
  localparam lk_state_t S_SELECT = 3'd3;
  localparam lk_state_t S_GW_READ = 3'd4;
  localparam lk_state_t S_DONE = 3'd5;
  typedef logic [1:0] reg_state_t;
  localparam reg_state_t R_WAIT = 2'd0;
  localparam reg_state_t R_WRITE = 2'd1;
  localparam reg_state_t R_READ = 2'd2;
  typedef struct packed {
    logic found;
    logic [4:0] idx;
  } first_t;
  function automatic first_t first_set_from(input logic [31:0] bitmap, input int start, input int n);
    first_t r;
    int j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      j = (start + i >= n) ? start + i - n : start + i;
      if (i < n && !r.found && bitmap[j[4:0]]) begin
        r.found = 1'b1;
        r.idx = j[4:0];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/lpm_lookup_mp_dpram.sv
// lpm_dpram: simple dual-port RAM, port A read-only, port B read/write, one-cycle registered reads.
module lpm_dpram #(
  parameter int W = 32,
  parameter int D = 32,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [W-1:0]  a_q,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_d,
  output logic [W-1:0]  b_q
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) begin
    if (a_en) a_q <= mem[a_addr];
    if (b_we) mem[b_addr] <= b_d;
    b_q <= mem[b_addr];
  end
endmodule

// File: rtl/lpm_lookup_mp.sv
// lpm_lookup_mp: longest-prefix-match scan with round-robin multipath port pick and gateway lookup.
// Define LPM_FAST_REROUTE_EN to mask candidate ports with the (registered) link status.
module lpm_lookup_mp
  import lpm_mp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int NUM_PORTS = 8,
  parameter int GW_DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int GW_AW = $clog2(GW_DEPTH),
  localparam int PW = $clog2(NUM_PORTS),
  localparam int ENTRY_W = HDR_W + GW_AW + NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_req,
  input  logic [31:0]          search_ip,
  output logic                 lookup_done,
  output logic                 hit,
  output logic [31:0]          nexthop_ip,
  output logic [NUM_PORTS-1:0] port,
  input  logic [NUM_PORTS-1:0] eth_link_status,
  input  logic                 multipath_enable,
  input  logic                 table_rd_req,
  output logic                 table_rd_ack,
  input  logic [AW-1:0]        table_rd_addr,
  output logic [ENTRY_W-1:0]   table_rd_data,
  input  logic                 table_wr_req,
  output logic                 table_wr_ack,
  input  logic [AW-1:0]        table_wr_addr,
  input  logic [ENTRY_W-1:0]   table_wr_data,
  input  logic                 gateway_table_rd_req,
  output logic                 gateway_table_rd_ack,
  input  logic [GW_AW-1:0]     gateway_table_rd_addr,
  output logic [31:0]          gateway_table_rd_data,
  input  logic                 gateway_table_wr_req,
  output logic                 gateway_table_wr_ack,
  input  logic [GW_AW-1:0]     gateway_table_wr_addr,
  input  logic [31:0]          gateway_table_wr_data
);
  lk_state_t st;
  reg_state_t rt_st, gw_st;
  logic [AW-1:0] scan_addr;
  logic drain, rd_v;
  logic [31:0] key;
  logic [ENTRY_W-1:0] rt_q;
  logic q_valid;
  logic [31:0] q_ip, q_mask;
  logic [GW_AW-1:0] q_gw;
  logic [NUM_PORTS-1:0] q_ports;
  logic c_match;
  logic [31:0] c_mask;
  logic [GW_AW-1:0] c_gw;
  logic [NUM_PORTS-1:0] c_ports;
  logic best_v;
  logic [31:0] best_mask;
  logic [GW_AW-1:0] best_gw;
  logic [NUM_PORTS-1:0] best_ports;
  logic [NUM_PORTS-1:0] cand;
  first_t fs;
  logic r_hit;
  logic [PW-1:0] r_idx, rr_ptr;
  logic [GW_AW-1:0] gw_addr;
  logic [31:0] gw_q;
  logic rt_we, gw_we;
  assign q_valid = rt_q[ENTRY_W-1-VALID_OFS];
  assign q_ip = rt_q[ENTRY_W-1-IP_OFS -: 32];
  assign q_mask = rt_q[ENTRY_W-1-MASK_OFS -: 32];
  assign q_gw = rt_q[NUM_PORTS +: GW_AW];
  assign q_ports = rt_q[0 +: NUM_PORTS];
  assign rt_we = rt_st == R_WRITE;
  assign gw_we = gw_st == R_WRITE;
  assign gw_addr = GW_AW'(32'(best_gw) + 32'(fs.idx));
`ifdef LPM_FAST_REROUTE_EN
  logic [NUM_PORTS-1:0] link_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) link_q <= '0;
    else link_q <= eth_link_status;
  end
  always_comb begin
    cand = best_v ? best_ports & link_q : '0;
    fs = first_set_from(32'(cand), multipath_enable ? int'(rr_ptr) : 0, NUM_PORTS);
  end
`else
  logic unused_link;
  assign unused_link = ^eth_link_status;
  always_comb begin
    cand = best_v ? best_ports : '0;
    fs = first_set_from(32'(cand), multipath_enable ? int'(rr_ptr) : 0, NUM_PORTS);
  end
`endif
  lpm_dpram #(.W(ENTRY_W), .D(DEPTH)) u_route (
    .clk(clk), .a_en(st == S_SCAN), .a_addr(scan_addr), .a_q(rt_q),
    .b_we(rt_we), .b_addr(rt_we ? table_wr_addr : table_rd_addr), .b_d(table_wr_data), .b_q(table_rd_data)
  );
  lpm_dpram #(.W(32), .D(GW_DEPTH)) u_gw (
    .clk(clk), .a_en(st == S_SELECT && fs.found), .a_addr(gw_addr), .a_q(gw_q),
    .b_we(gw_we), .b_addr(gw_we ? gateway_table_wr_addr : gateway_table_rd_addr),
    .b_d(gateway_table_wr_data), .b_q(gateway_table_rd_data)
  );
  // Scan pipeline: RAM read -> compare register -> best-entry update, drained by S_DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= S_IDLE;
      scan_addr <= '0;
      drain <= 1'b0;
      key <= '0;
      rd_v <= 1'b0;
      c_match <= 1'b0;
      c_mask <= '0;
      c_gw <= '0;
      c_ports <= '0;
      best_v <= 1'b0;
      best_mask <= '0;
      best_gw <= '0;
      best_ports <= '0;
      r_hit <= 1'b0;
      r_idx <= '0;
      rr_ptr <= '0;
      lookup_done <= 1'b0;
      hit <= 1'b0;
      port <= '0;
      nexthop_ip <= '1;
    end else begin
      rd_v <= st == S_SCAN;
      c_match <= rd_v && q_valid && ((q_ip ^ key) & q_mask) == 32'd0;
      c_mask <= q_mask;
      c_gw <= q_gw;
      c_ports <= q_ports;
      if (c_match && (!best_v || c_mask > best_mask)) begin
        best_v <= 1'b1;
        best_mask <= c_mask;
        best_gw <= c_gw;
        best_ports <= c_ports;
      end
      lookup_done <= st == S_GW_READ;
      case (st)
        S_IDLE: if (lookup_req) begin
          st <= S_SCAN;
          key <= search_ip;
          scan_addr <= '0;
          best_v <= 1'b0;
        end
        S_SCAN: begin
          scan_addr <= scan_addr + 1'b1;
          drain <= 1'b0;
          if (scan_addr == AW'(DEPTH - 1)) st <= S_DRAIN;
        end
        S_DRAIN: begin
          drain <= 1'b1;
          if (drain) st <= S_SELECT;
        end
        S_SELECT: begin
          r_hit <= fs.found;
          r_idx <= fs.idx[PW-1:0];
          if (fs.found && multipath_enable)
            rr_ptr <= (fs.idx[PW-1:0] == PW'(NUM_PORTS - 1)) ? '0 : fs.idx[PW-1:0] + 1'b1;
          st <= S_GW_READ;
        end
        S_GW_READ: begin
          hit <= r_hit;
          port <= r_hit ? NUM_PORTS'(1) << r_idx : '0;
          nexthop_ip <= r_hit ? gw_q : '1;
          st <= S_DONE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
  // Register ports: write wins over read; a still-held req is serviced again from WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rt_st <= R_WAIT;
      table_wr_ack <= 1'b0;
      table_rd_ack <= 1'b0;
    end else begin
      rt_st <= rt_st == R_WAIT ? (table_wr_req ? R_WRITE : table_rd_req ? R_READ : R_WAIT) : R_WAIT;
      table_wr_ack <= rt_st == R_WRITE;
      table_rd_ack <= rt_st == R_READ;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gw_st <= R_WAIT;
      gateway_table_wr_ack <= 1'b0;
      gateway_table_rd_ack <= 1'b0;
    end else begin
      gw_st <= gw_st == R_WAIT ? (gateway_table_wr_req ? R_WRITE : gateway_table_rd_req ? R_READ : R_WAIT) : R_WAIT;
      gateway_table_wr_ack <= gw_st == R_WRITE;
      gateway_table_rd_ack <= gw_st == R_READ;
    end
  end
endmodule

// File: tb/tb_lpm_lookup_mp.sv
// tb_lpm_lookup_mp: scoreboard bench for lpm_lookup_mp; expectations come from a software route/gateway model.
module tb_lpm_lookup_mp;
  localparam int DEPTH = 64;
  localparam int NUM_PORTS = 8;
  localparam int GW_DEPTH = 32;
  localparam int AW = 6;
  localparam int GW_AW = 5;
  localparam int ENTRY_W = 65 + GW_AW + NUM_PORTS;
  typedef struct packed {
    logic hit;
    logic [7:0] port;
    logic [31:0] nh;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  logic lookup_req = 0;
  logic [31:0] search_ip = '0;
  logic lookup_done, hit;
  logic [31:0] nexthop_ip;
  logic [NUM_PORTS-1:0] port;
  logic [NUM_PORTS-1:0] eth_link_status = '1;
  logic multipath_enable = 0;
  logic table_rd_req = 0, table_rd_ack;
  logic [AW-1:0] table_rd_addr = '0;
  logic [ENTRY_W-1:0] table_rd_data;
  logic table_wr_req = 0, table_wr_ack;
  logic [AW-1:0] table_wr_addr = '0;
  logic [ENTRY_W-1:0] table_wr_data = '0;
  logic gateway_table_rd_req = 0, gateway_table_rd_ack;
  logic [GW_AW-1:0] gateway_table_rd_addr = '0;
  logic [31:0] gateway_table_rd_data;
  logic gateway_table_wr_req = 0, gateway_table_wr_ack;
  logic [GW_AW-1:0] gateway_table_wr_addr = '0;
  logic [31:0] gateway_table_wr_data = '0;
  logic [ENTRY_W-1:0] m_rt [DEPTH];
  logic [31:0] m_gw [GW_DEPTH];
  int m_rr = 0;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  lpm_lookup_mp #(.DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS), .GW_DEPTH(GW_DEPTH)) dut (
    .clk(clk), .reset(reset), .lookup_req(lookup_req), .search_ip(search_ip),
    .lookup_done(lookup_done), .hit(hit), .nexthop_ip(nexthop_ip), .port(port),
    .eth_link_status(eth_link_status), .multipath_enable(multipath_enable),
    .table_rd_req(table_rd_req), .table_rd_ack(table_rd_ack), .table_rd_addr(table_rd_addr), .table_rd_data(table_rd_data),
    .table_wr_req(table_wr_req), .table_wr_ack(table_wr_ack), .table_wr_addr(table_wr_addr), .table_wr_data(table_wr_data),
    .gateway_table_rd_req(gateway_table_rd_req), .gateway_table_rd_ack(gateway_table_rd_ack),
    .gateway_table_rd_addr(gateway_table_rd_addr), .gateway_table_rd_data(gateway_table_rd_data),
    .gateway_table_wr_req(gateway_table_wr_req), .gateway_table_wr_ack(gateway_table_wr_ack),
    .gateway_table_wr_addr(gateway_table_wr_addr), .gateway_table_wr_data(gateway_table_wr_data)
  );
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [ENTRY_W-1:0] mk(input logic v, input logic [31:0] ip, input logic [31:0] mask,
                                            input logic [GW_AW-1:0] gw, input logic [7:0] ports);
    return {v, ip, mask, gw, ports};
  endfunction
  task automatic wr_rt(input int a, input logic [ENTRY_W-1:0] d, output int lat);
    @(posedge clk); #1;
    table_wr_addr = AW'(a);
    table_wr_data = d;
    table_wr_req = 1;
    lat = 0;
    while (!table_wr_ack && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    table_wr_req = 0;
    if (!table_wr_ack) check("rt_wr_ack_timeout", 0, 1);
    m_rt[a] = d;
  endtask
  task automatic wr_gw(input int a, input logic [31:0] d);
    int lat;
    @(posedge clk); #1;
    gateway_table_wr_addr = GW_AW'(a);
    gateway_table_wr_data = d;
    gateway_table_wr_req = 1;
    lat = 0;
    while (!gateway_table_wr_ack && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    gateway_table_wr_req = 0;
    if (!gateway_table_wr_ack) check("gw_wr_ack_timeout", 0, 1);
    m_gw[a] = d;
  endtask
  task automatic predict(input logic [31:0] key);
    exp_t e;
    int best, blen, sel, start, j;
    logic [ENTRY_W-1:0] ent;
    logic [7:0] cand;
    logic [GW_AW-1:0] gb;
    best = -1;
    blen = -1;
    cand = '0;
    gb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent = m_rt[i];
      if (ent[77] && ((ent[76:45] ^ key) & ent[44:13]) == 0 && $countones(ent[44:13]) > blen) begin
        best = i;
        blen = $countones(ent[44:13]);
        cand = ent[7:0];
        gb = ent[12:8];
      end
    end
`ifdef LPM_FAST_REROUTE_EN
    cand = cand & eth_link_status;
`endif
    sel = -1;
    start = multipath_enable ? m_rr : 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = (start + k) % NUM_PORTS;
      if (sel < 0 && cand[j]) sel = j;
    end
    if (sel < 0) begin
      e.hit = 0;
      e.port = '0;
      e.nh = 32'hffffffff;
    end else begin
      e.hit = 1;
      e.port = 8'(1 << sel);
      e.nh = m_gw[(int'(gb) + sel) % GW_DEPTH];
      if (multipath_enable) m_rr = (sel + 1) % NUM_PORTS;
    end
    sb.push_back(e);
  endtask
  task automatic start_lookup(input logic [31:0] key, output int t0);
    @(posedge clk); #1;
    search_ip = key;
    lookup_req = 1;
    @(posedge clk); #1;
    lookup_req = 0;
    t0 = cyc;
  endtask
  task automatic finish_lookup(input string tag, input int t0);
    exp_t e;
    int n;
    n = 0;
    while (!lookup_done && n < DEPTH + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 80'(cyc - t0), 80'(DEPTH + 4));
    if (sb.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else begin
      e = sb.pop_front();
      check({tag, "_hit"}, hit, e.hit);
      check({tag, "_port"}, port, e.port);
      check({tag, "_nexthop"}, nexthop_ip, e.nh);
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, lookup_done, 0);
  endtask
  task automatic lookup(input string tag, input logic [31:0] key);
    int t0;
    start_lookup(key, t0);
    predict(key);
    finish_lookup(tag, t0);
  endtask
  initial begin
    int lat, t0, seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", lookup_done, 0);
    check("rst_hit", hit, 0);
    check("rst_port", port, 0);
    check("rst_nexthop", nexthop_ip, 32'hffffffff);
    check("rst_acks", {table_rd_ack, table_wr_ack, gateway_table_rd_ack, gateway_table_wr_ack}, 0);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) wr_rt(i, '0, lat);
    for (int i = 0; i < GW_DEPTH; i++) wr_gw(i, 32'h0a0a0000 | i);
    lookup("empty", 32'h01020304);
    wr_rt(0, mk(1, 32'h0, 32'h0, 5, 8'h02), lat);
    wr_gw(6, 32'hc0a80001);
    lookup("default", 32'h01020304);
    wr_rt(3, mk(1, 32'h0a000000, 32'hff000000, 0, 8'h01), lat);
    wr_rt(7, mk(1, 32'h0a010000, 32'hffff0000, 3, 8'h04), lat);
    lookup("lpm16", 32'h0a010203);
    lookup("lpm8", 32'h0ac80001);
    lookup("lpm_dflt", 32'h0b000001);
    wr_rt(9, mk(1, 32'h0a010000, 32'hffff0000, 1, 8'h08), lat);
    lookup("tie", 32'h0a01ffff);
    @(posedge clk); #1;
    table_rd_addr = 7;
    table_rd_req = 1;
    lat = 0;
    while (!table_rd_ack && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    table_rd_req = 0;
    check("rd_ack_latency", lat, 2);
    check("rd_data", table_rd_data, m_rt[7]);
    wr_rt(0, '0, lat);
    lookup("miss", 32'h0b000001);
    wr_rt(12, mk(1, 32'hc0a80100, 32'hffffff00, 31, 8'h04), lat);
    lookup("gw_wrap", 32'hc0a80107);
    for (int i = 3; i <= 12; i++) if (m_rt[i] != '0) wr_rt(i, '0, lat);
    wr_rt(5, mk(1, 32'h0, 32'h0, 10, 8'h51), lat);
    multipath_enable = 1;
    lookup("mp0", 32'h12345678);
    lookup("mp1", 32'h12345678);
    lookup("mp2", 32'h12345678);
    lookup("mp3", 32'h12345678);
    multipath_enable = 0;
    lookup("mp_off", 32'h12345678);
    multipath_enable = 1;
    lookup("mp_resume", 32'h12345678);
    multipath_enable = 0;
    wr_rt(5, mk(1, 32'h0, 32'h0, 10, 8'h05), lat);
    eth_link_status = 8'hfe;
    lookup("link_fe", 32'h01010101);
    eth_link_status = 8'hfa;
    lookup("link_fa", 32'h01010101);
    eth_link_status = 8'hff;
    start_lookup(32'h01010101, t0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    #1;
    check("midrst_done", lookup_done, 0);
    check("midrst_hit", hit, 0);
    check("midrst_port", port, 0);
    check("midrst_nexthop", nexthop_ip, 32'hffffffff);
    m_rr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    seen = 0;
    repeat (DEPTH + 10) begin
      @(posedge clk); #1;
      if (lookup_done) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_hold_port", port, 0);
    start_lookup(32'hc0a80199, t0);
    wr_rt(60, mk(1, 32'hc0a80100, 32'hffffff00, 2, 8'h80), lat);
    check("scan_wr_ack_latency", lat, 2);
    predict(32'hc0a80199);
    finish_lookup("scan_wr", t0);
    lookup("after_rst", 32'h01010101);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
